// File: rtl/systolic_array_ws.sv
// ============================================================================
// Module   : systolic_array_ws
// Brief    : Weight-stationary ROWS x COLS systolic matrix-vector engine with
//            double-buffered weights and a drain-then-swap weight controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_array_ws #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_load_en,
    input  logic [$clog2(ROWS)-1:0]   w_row_addr,
    input  logic [COLS*DATA_W-1:0]    w_row_in,
    input  logic                      w_swap,
    output logic                      w_swap_done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*DATA_W-1:0]    in_vec_flat,
    output logic                      out_valid,
    output logic [COLS*ACC_W-1:0]     out_sum_flat
);

    localparam int c_LAT   = ROWS + COLS - 1;
    localparam int c_CNT_W = $clog2(c_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_INF_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_SWAP  = 2'd2;

    if (ACC_W < 2*DATA_W) begin : g_param_check
        $error("systolic_array_ws: ACC_W must be at least 2*DATA_W");
    end

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [c_CNT_W-1:0]        r_inflight;
    logic [c_LAT-1:0]          r_valid;
    logic                      w_accept;

    logic signed [DATA_W-1:0]  r_wsh   [ROWS][COLS];
    logic signed [DATA_W-1:0]  r_wact  [ROWS][COLS];
    logic signed [DATA_W-1:0]  r_act   [ROWS][COLS];
    logic signed [ACC_W-1:0]   r_psum  [ROWS][COLS];
    logic signed [DATA_W-1:0]  w_pe_a  [ROWS][COLS];
    logic signed [ACC_W-1:0]   w_pe_s  [ROWS][COLS];
    logic signed [2*DATA_W-1:0] w_prod [ROWS][COLS];
    logic signed [DATA_W-1:0]  w_a_west [ROWS];
    logic signed [ACC_W-1:0]   w_col_out [COLS];

    assign w_accept = in_valid && in_ready;

    // ---------------- weight-control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_RUN;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_swap)
                    w_next_state = (r_inflight == '0 && !w_accept) ? c_ST_SWAP : c_ST_DRAIN;
            end
            c_ST_DRAIN: if (r_inflight == '0) w_next_state = c_ST_SWAP;
            c_ST_SWAP:  w_next_state = c_ST_RUN;
            default:    w_next_state = c_ST_RUN;
        endcase
    end

    // Reset overrides the state decode so outputs are defined while rst is high.
    always_comb begin
        in_ready    = rst || (r_state == c_ST_RUN);
        w_swap_done = !rst && (r_state == c_ST_SWAP);
        out_valid   = !rst && r_valid[c_LAT-1];
    end

    // ---------------- occupancy and valid pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_valid    <= '0;
        end else begin
            r_valid <= {r_valid[c_LAT-2:0], w_accept};
            case ({w_accept, out_valid})
                2'b10:   r_inflight <= r_inflight + c_INF_ONE;
                2'b01:   r_inflight <= r_inflight - c_INF_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ---------------- weight banks ----------------
    // The swap copy reads the shadow before any same-cycle row write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_wsh[r][c]  <= '0;
                    r_wact[r][c] <= '0;
                end
            end
        end else begin
            if (r_state == c_ST_SWAP) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        r_wact[r][c] <= r_wsh[r][c];
            end
            if (w_load_en && int'(w_row_addr) < ROWS) begin
                for (int c = 0; c < COLS; c++)
                    r_wsh[w_row_addr][c] <= w_row_in[c*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- input skew ----------------
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic signed [DATA_W-1:0] w_a_in;
        assign w_a_in = w_accept ? in_vec_flat[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign w_a_west[r] = w_a_in;
        end else begin : g_delay
            logic signed [DATA_W-1:0] r_sk [r];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_a_in;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_a_west[r] = r_sk[r-1];
        end
    end

    // ---------------- PE grid ----------------
    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            if (c == 0) begin : g_west_edge
                assign w_pe_a[r][c] = w_a_west[r];
            end else begin : g_west_pe
                assign w_pe_a[r][c] = r_act[r][c-1];
            end
            if (r == 0) begin : g_north_edge
                assign w_pe_s[r][c] = '0;
            end else begin : g_north_pe
                assign w_pe_s[r][c] = r_psum[r-1][c];
            end
            assign w_prod[r][c] = (2*DATA_W)'(w_pe_a[r][c]) * (2*DATA_W)'(r_wact[r][c]);
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rst) begin
                    r_act[r][c]  <= '0;
                    r_psum[r][c] <= '0;
                end else begin
                    r_act[r][c]  <= w_pe_a[r][c];
                    r_psum[r][c] <= w_pe_s[r][c] + ACC_W'(w_prod[r][c]);
                end
            end
        end
    end

    // ---------------- output deskew ----------------
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int c_DEPTH = COLS - 1 - c;
        if (c_DEPTH == 0) begin : g_direct
            assign w_col_out[c] = r_psum[ROWS-1][c];
        end else begin : g_delay
            logic signed [ACC_W-1:0] r_dk [c_DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c_DEPTH; i++) r_dk[i] <= '0;
                end else begin
                    r_dk[0] <= r_psum[ROWS-1][c];
                    for (int i = 1; i < c_DEPTH; i++) r_dk[i] <= r_dk[i-1];
                end
            end
            assign w_col_out[c] = r_dk[c_DEPTH-1];
        end
    end

    always_comb begin
        out_sum_flat = '0;
        for (int c = 0; c < COLS; c++)
            if (out_valid) out_sum_flat[c*ACC_W +: ACC_W] = w_col_out[c];
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_ws.sv
// ============================================================================
// Module   : tb_systolic_array_ws
// Brief    : Directed self-checking bench for systolic_array_ws (4x4, 8b/32b).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_array_ws;

    logic         clk = 1'b0;
    logic         rst;
    logic         w_load_en;
    logic [1:0]   w_row_addr;
    logic [31:0]  w_row_in;
    logic         w_swap;
    logic         w_swap_done;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_vec_flat;
    logic         out_valid;
    logic [127:0] out_sum_flat;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int nz_err  = 0;
    int q_cyc[$];
    logic [127:0] q_val[$];

    systolic_array_ws #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .w_load_en   (w_load_en),
        .w_row_addr  (w_row_addr),
        .w_row_in    (w_row_in),
        .w_swap      (w_swap),
        .w_swap_done (w_swap_done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec_flat (in_vec_flat),
        .out_valid   (out_valid),
        .out_sum_flat(out_sum_flat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every presented result with its cycle index.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_val.push_back(out_sum_flat);
        end else if (out_sum_flat !== '0) begin
            nz_err++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] p8(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [127:0] p32(input int s0, input int s1, input int s2, input int s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic load_row(input logic [1:0] addr, input logic [31:0] row);
        w_load_en = 1'b1; w_row_addr = addr; w_row_in = row;
        @(negedge clk);
        w_load_en = 1'b0;
    endtask

    task automatic do_swap();
        w_swap = 1'b1;
        @(negedge clk);
        w_swap = 1'b0;
        for (int t = 0; t < 30 && !in_ready; t++) @(negedge clk);
    endtask

    task automatic send_vec(input logic [31:0] v, output int ac, output logic ok);
        in_vec_flat = v; in_valid = 1'b1; ok = 1'b0; ac = -1;
        for (int t = 0; t < 30; t++) begin
            if (in_ready) begin ac = cyc; ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_vec_flat = '0;
    endtask

    task automatic get_result(output logic ok, output int oc, output logic [127:0] ov);
        ok = 1'b0; oc = -1; ov = '0;
        for (int t = 0; t < 40; t++) begin
            if (q_cyc.size() > 0) begin
                ok = 1'b1; oc = q_cyc.pop_front(); ov = q_val.pop_front();
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int ac, oc; logic ok, rok; logic [127:0] ov;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (w_swap_done !== 1'b0) $display("FAIL rst_swap_done: got %b want 0", w_swap_done); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_sum_flat !== '0) $display("FAIL post_rst_out_sum: got %h want 0", out_sum_flat); else n_pass++;
        q_cyc.delete(); q_val.delete();
        send_vec(p8(1, 2, 3, 4), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || oc != ac + 7) $display("FAIL rst_latency: got %0d want %0d", oc - ac, 7); else n_pass++;
        n_total++; if (ov !== '0) $display("FAIL rst_zero_weights: got %h want 0", ov); else n_pass++;
    endtask

    task automatic test_identity();
        int ac, oc; logic ok, rok; logic [127:0] ov;
        load_row(2'd0, p8(1, 0, 0, 0));
        load_row(2'd1, p8(0, 1, 0, 0));
        load_row(2'd2, p8(0, 0, 1, 0));
        load_row(2'd3, p8(0, 0, 0, 1));
        w_swap = 1'b1;
        @(negedge clk);
        w_swap = 1'b0;
        n_total++; if (w_swap_done !== 1'b1) $display("FAIL id_swap_done_hi: got %b want 1", w_swap_done); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL id_swap_in_ready: got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (w_swap_done !== 1'b0) $display("FAIL id_swap_done_lo: got %b want 0", w_swap_done); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL id_run_in_ready: got %b want 1", in_ready); else n_pass++;
        q_cyc.delete(); q_val.delete();
        send_vec(p8(1, 2, 3, 4), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || oc != ac + 7) $display("FAIL id_latency: got %0d want %0d", oc - ac, 7); else n_pass++;
        n_total++; if (ov !== p32(1, 2, 3, 4)) $display("FAIL id_value: got %h want %h", ov, p32(1, 2, 3, 4)); else n_pass++;
    endtask

    task automatic test_signed_extremes();
        int ac, oc; logic ok, rok; logic [127:0] ov;
        for (int r = 0; r < 4; r++) load_row(2'(r), p8(-128, -128, -128, -128));
        do_swap();
        q_cyc.delete(); q_val.delete();
        send_vec(p8(-128, -128, -128, -128), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || ov !== p32(65536, 65536, 65536, 65536))
            $display("FAIL signed_neg_neg: got %h want %h", ov, p32(65536, 65536, 65536, 65536)); else n_pass++;
        for (int r = 0; r < 4; r++) load_row(2'(r), p8(127, 127, 127, 127));
        do_swap();
        send_vec(p8(-128, -128, -128, -128), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || ov !== p32(-65024, -65024, -65024, -65024))
            $display("FAIL signed_pos_neg: got %h want %h", ov, p32(-65024, -65024, -65024, -65024)); else n_pass++;
    endtask

    task automatic test_swap_under_traffic();
        logic [31:0]  vecs [5];
        logic [127:0] exps [5];
        int acc [5];
        int low_cnt, done_cyc, oc;
        logic got, rok; logic [127:0] ov;
        vecs[0] = p8(1, 2, 3, 4);     exps[0] = p32(1, 2, 3, 4);
        vecs[1] = p8(5, 6, 7, 8);     exps[1] = p32(5, 6, 7, 8);
        vecs[2] = p8(-1, -2, -3, -4); exps[2] = p32(-1, -2, -3, -4);
        vecs[3] = p8(10, 20, 30, 40); exps[3] = p32(20, 40, 60, 80);
        vecs[4] = p8(3, 0, -7, 9);    exps[4] = p32(6, 0, -14, 18);
        load_row(2'd0, p8(1, 0, 0, 0));
        load_row(2'd1, p8(0, 1, 0, 0));
        load_row(2'd2, p8(0, 0, 1, 0));
        load_row(2'd3, p8(0, 0, 0, 1));
        do_swap();
        load_row(2'd0, p8(2, 0, 0, 0));
        load_row(2'd1, p8(0, 2, 0, 0));
        load_row(2'd2, p8(0, 0, 2, 0));
        load_row(2'd3, p8(0, 0, 0, 2));
        q_cyc.delete(); q_val.delete();
        low_cnt = 0; done_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            in_vec_flat = vecs[i]; in_valid = 1'b1; w_swap = (i == 2); got = 1'b0; acc[i] = -1;
            for (int t = 0; t < 30 && !got; t++) begin
                if (w_swap_done) done_cyc = cyc;
                if (in_ready) begin acc[i] = cyc; got = 1'b1; end
                else low_cnt++;
                @(negedge clk);
                w_swap = 1'b0;
            end
        end
        in_valid = 1'b0; in_vec_flat = '0;
        n_total++; if (low_cnt != 9) $display("FAIL swap_ready_low: got %0d want 9", low_cnt); else n_pass++;
        n_total++; if (done_cyc != acc[2] + 9) $display("FAIL swap_done_cycle: got %0d want %0d", done_cyc - acc[2], 9); else n_pass++;
        n_total++; if (acc[3] != acc[2] + 10 || acc[4] != acc[3] + 1)
            $display("FAIL swap_accepts: got %0d,%0d want 10,1", acc[3] - acc[2], acc[4] - acc[3]); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            get_result(rok, oc, ov);
            n_total++; if (!rok || oc != acc[i] + 7) $display("FAIL swap_lat_v%0d: got %0d want 7", i + 1, oc - acc[i]); else n_pass++;
            n_total++; if (ov !== exps[i]) $display("FAIL swap_val_v%0d: got %h want %h", i + 1, ov, exps[i]); else n_pass++;
        end
        repeat (12) @(negedge clk);
        n_total++; if (q_cyc.size() != 0) $display("FAIL swap_extra_results: got %0d want 0", q_cyc.size()); else n_pass++;
    endtask

    task automatic test_load_and_swap();
        int ac, oc; logic ok, rok; logic [127:0] ov;
        load_row(2'd0, p8(7, 0, 0, 0));
        w_swap = 1'b1;
        @(negedge clk);
        w_swap = 1'b0;
        n_total++; if (w_swap_done !== 1'b1) $display("FAIL ls_swap_done: got %b want 1", w_swap_done); else n_pass++;
        w_load_en = 1'b1; w_row_addr = 2'd0; w_row_in = p8(5, 5, 5, 5);
        @(negedge clk);
        w_load_en = 1'b0;
        q_cyc.delete(); q_val.delete();
        send_vec(p8(1, 1, 0, 0), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || ov !== p32(7, 2, 0, 0))
            $display("FAIL ls_active_old: got %h want %h", ov, p32(7, 2, 0, 0)); else n_pass++;
        do_swap();
        send_vec(p8(1, 1, 0, 0), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || ov !== p32(5, 7, 5, 5))
            $display("FAIL ls_shadow_new: got %h want %h", ov, p32(5, 7, 5, 5)); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int ac, oc; logic ok, rok; logic [127:0] ov;
        q_cyc.delete(); q_val.delete();
        in_valid = 1'b1; in_vec_flat = p8(9, 9, 9, 9);
        @(negedge clk);
        in_vec_flat = p8(4, 3, 2, 1);
        @(negedge clk);
        in_valid = 1'b0; in_vec_flat = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        n_total++; if (q_cyc.size() != 0) $display("FAIL mid_rst_results: got %0d want 0", q_cyc.size()); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else n_pass++;
        w_swap = 1'b1;
        @(negedge clk);
        w_swap = 1'b0;
        n_total++; if (w_swap_done !== 1'b1) $display("FAIL mid_rst_inflight_zero: got %b want 1", w_swap_done); else n_pass++;
        @(negedge clk);
        send_vec(p8(1, 1, 1, 1), ac, ok);
        get_result(rok, oc, ov);
        n_total++; if (!ok || !rok || ov !== '0) $display("FAIL mid_rst_banks_clear: got %h want 0", ov); else n_pass++;
        n_total++; if (nz_err != 0) $display("FAIL idle_out_sum_nonzero: got %0d want 0", nz_err); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; w_load_en = 1'b0; w_row_addr = '0; w_row_in = '0;
        w_swap = 1'b0; in_valid = 1'b0; in_vec_flat = '0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_signed_extremes();
        test_swap_under_traffic();
        test_load_and_swap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
